// File: rtl/fwd_pkg.sv
// Shared types and helpers for the decode forwarding / hazard unit.
// Holds the controller state encoding, the register-zero address constant
// and the slice-offset helper used to unpack per-port buses.
package fwd_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Architectural zero register: never forwarded, always read from the file.
    localparam int unsigned ADDR_ZERO = 0;

    // Low bit of element k in a flat bus of w-bit elements.
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/fwd_pred_queue.sv
// Purpose: FIFO of predicted values awaiting verification in MEM.
// Latency: push visible in count/head next cycle; head is read combinationally.
// Backpressure: push ignored when full unless popping the same cycle; pop ignored when empty; clear wins.
// Ports: clk/rst_n, push+push_data, pop, clear -> full, empty, count, head.
module fwd_pred_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue may still accept an entry when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Purpose: decode operand forwarding (EX>MEM>WB), value-prediction injection, load-use stall, mispredict flush.
// Latency: operands and o_Stall combinational; o_Flush/counters registered (one cycle after the failing resolve).
// Backpressure: o_Stall holds decode on hazards, on a full prediction queue, and for FLUSH_CYCLES after a flush.
// Ports: i_DEC_* read ports, i_EX/MEM/WB_* producers, i_Predict_*, i_MEM_Resolve, i_Squash -> operands, stall, flush, counts.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 2,
    parameter int PRED_Q_DEPTH   = 4,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic                                   i_Clk,
    input  logic                                   i_Reset_n,
    input  logic [NUM_SRC-1:0]                     i_DEC_Uses,
    input  logic [NUM_SRC*(REG_ADDR_WIDTH+1)-1:0]  i_DEC_Addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]          i_DEC_Data,
    input  logic                                   i_DEC_Advance,
    input  logic                                   i_EX_Writes_Back,
    input  logic                                   i_EX_Valid,
    input  logic [REG_ADDR_WIDTH:0]                i_EX_Write_Addr,
    input  logic [DATA_WIDTH-1:0]                  i_EX_Write_Data,
    input  logic                                   i_MEM_Writes_Back,
    input  logic [REG_ADDR_WIDTH:0]                i_MEM_Write_Addr,
    input  logic [DATA_WIDTH-1:0]                  i_MEM_Write_Data,
    input  logic                                   i_MEM_Resolve,
    input  logic                                   i_WB_Writes_Back,
    input  logic [REG_ADDR_WIDTH:0]                i_WB_Write_Addr,
    input  logic [DATA_WIDTH-1:0]                  i_WB_Write_Data,
    input  logic                                   i_Predict_Made,
    input  logic [DATA_WIDTH-1:0]                  i_Predicted_Data,
    input  logic                                   i_Squash,
    output logic [NUM_SRC*DATA_WIDTH-1:0]          o_DEC_Override_Data,
    output logic                                   o_Stall,
    output logic                                   o_Flush,
    output logic [$clog2(PRED_Q_DEPTH):0]          o_Pred_Q_Count,
    output logic [15:0]                            o_Mispredict_Count
);

    localparam int AW  = REG_ADDR_WIDTH + 1;
    localparam int FCW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ADDR_ZERO);

    state_t               state;
    state_t               state_nxt;
    logic [FCW-1:0]       flush_cnt;
    logic [NUM_SRC-1:0]   hazard;
    logic [NUM_SRC-1:0]   pred_used;
    logic                 pred_use;
    logic                 q_full;
    logic                 q_empty;
    logic                 q_push;
    logic                 q_pop;
    logic                 q_clear;
    logic                 mispredict;
    logic                 run;
    logic [DATA_WIDTH-1:0] q_head;

    // ---------------- per-port forwarding ----------------
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_port
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] rf_data;
        logic [DATA_WIDTH-1:0] fwd_data;
        logic                  rd_en;
        logic                  ex_hit;
        logic                  mem_hit;
        logic                  wb_hit;
        logic                  hz;
        logic                  pu;

        assign addr    = i_DEC_Addr[slice_lo(k, AW) +: AW];
        assign rf_data = i_DEC_Data[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
        // Zero register reads never match a producer.
        assign rd_en   = i_DEC_Uses[k] && (addr != ZERO_ADDR);
        assign ex_hit  = rd_en && i_EX_Writes_Back  && (addr == i_EX_Write_Addr);
        assign mem_hit = rd_en && i_MEM_Writes_Back && (addr == i_MEM_Write_Addr);
        assign wb_hit  = rd_en && i_WB_Writes_Back  && (addr == i_WB_Write_Addr);

        always_comb begin
            fwd_data = rf_data;
            hz       = 1'b0;
            pu       = 1'b0;
            if (ex_hit) begin
                // The youngest producer owns the register even if its value is not ready.
                if (i_EX_Valid)          fwd_data = i_EX_Write_Data;
                else if (i_Predict_Made) begin
                    fwd_data = i_Predicted_Data;
                    pu       = 1'b1;
                end else                 hz = 1'b1;
            end else if (mem_hit) begin
                fwd_data = i_MEM_Write_Data;
            end else if (wb_hit) begin
                fwd_data = i_WB_Write_Data;
            end
        end

        assign o_DEC_Override_Data[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] = fwd_data;
        assign hazard[k]    = hz;
        assign pred_used[k] = pu;
    end

    // ---------------- prediction queue ----------------
    assign run        = (state == RUN);
    assign pred_use   = |pred_used;
    assign q_pop      = run && i_MEM_Resolve && !q_empty;
    assign mispredict = q_pop && (q_head != i_MEM_Write_Data);
    // One entry per advancing instruction, regardless of how many ports consumed it.
    assign q_push     = run && pred_use && i_DEC_Advance && !o_Stall;
    assign q_clear    = mispredict || i_Squash;

    fwd_pred_queue #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (PRED_Q_DEPTH)
    ) u_pred_queue (
        .clk       (i_Clk),
        .rst_n     (i_Reset_n),
        .push      (q_push),
        .push_data (i_Predicted_Data),
        .pop       (q_pop),
        .clear     (q_clear),
        .full      (q_full),
        .empty     (q_empty),
        .count     (o_Pred_Q_Count),
        .head      (q_head)
    );

    // ---------------- controller ----------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= RUN;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mispredict)       state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == '0)  state_nxt = RUN;
            default:                       state_nxt = RUN;
        endcase
    end

    always_comb begin
        o_Stall = 1'b0;
        if (i_Reset_n) begin
            if (state == FLUSH) o_Stall = 1'b1;
            // A full queue only blocks a new prediction if the head is not retiring now.
            else                o_Stall = (|hazard) || (pred_use && q_full && !i_MEM_Resolve);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            flush_cnt          <= '0;
            o_Flush            <= 1'b0;
            o_Mispredict_Count <= '0;
        end else begin
            o_Flush <= mispredict;
            if (mispredict) begin
                flush_cnt <= FCW'(FLUSH_CYCLES - 1);
                if (o_Mispredict_Count != 16'hFFFF)
                    o_Mispredict_Count <= o_Mispredict_Count + 16'd1;
            end else if (state == FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - FCW'(1);
            end
        end
    end

endmodule
